// File: rtl/custom_types_pkg.sv
// Shared types for the decode-stage issue scoreboard: the in-flight entry
// record and the forwarding-select encoding.
package custom_types_pkg;

    localparam int SB_REG_W = 5;

    // Forwarding select value meaning "read the register file".
    localparam int FWD_RF = 0;

    typedef struct packed {
        logic                valid;
        logic [SB_REG_W-1:0] dst;
        logic                load;
    } scoreboard_ent_t;

endpackage

// File: rtl/sb_match.sv
// Priority finder for one source operand: reports whether any in-flight
// entry writes the operand, and which entry (youngest first) it is.
module sb_match
    import custom_types_pkg::*;
#(
    parameter int PIPE_DEPTH = 3,
    parameter int IDX_W      = 2
) (
    input  scoreboard_ent_t [PIPE_DEPTH-1:0] ents_i,
    input  logic [SB_REG_W-1:0]              src_i,
    input  logic                             use_src_i,
    output logic                             hit_o,
    output logic [IDX_W-1:0]                 idx_o,
    output logic                             load_o
);

    // Walk oldest to youngest so the youngest match is the last one written.
    always_comb begin
        hit_o  = 1'b0;
        idx_o  = '0;
        load_o = 1'b0;
        for (int i = PIPE_DEPTH - 1; i >= 0; i--) begin
            if (use_src_i && (src_i != '0) && ents_i[i].valid && (ents_i[i].dst == src_i)) begin
                hit_o  = 1'b1;
                idx_o  = IDX_W'(i);
                load_o = ents_i[i].load;
            end
        end
    end

endmodule

// File: rtl/decode_scoreboard.sv
// Decode-stage issue scoreboard: tracks in-flight destination registers and
// decides issue / forward / stall for the instruction currently in decode.
module decode_scoreboard
    import custom_types_pkg::*;
#(
    parameter int PIPE_DEPTH = 3,
    parameter int LOAD_READY = 2,
    parameter int FORWARD    = 1,
    parameter int REG_W      = SB_REG_W,
    parameter int FWD_W      = $clog2(PIPE_DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             mem_freeze,
    input  logic             flush,
    input  logic             issue_valid,
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] rt,
    input  logic             use_rs,
    input  logic             use_rt,
    input  logic [REG_W-1:0] dst,
    input  logic             dst_wen,
    input  logic             dst_load,
    output logic             stall,
    output logic [FWD_W-1:0] fwd_a,
    output logic [FWD_W-1:0] fwd_b,
    output logic             [FWD_W-1:0] inflight
);

    localparam logic [FWD_W-1:0] LOAD_READY_W = FWD_W'(LOAD_READY);
    localparam logic [FWD_W-1:0] FWD_RF_W     = FWD_W'(FWD_RF);

    scoreboard_ent_t [PIPE_DEPTH-1:0] ents_q;
    scoreboard_ent_t [PIPE_DEPTH-1:0] ents_d;

    logic [1:0][REG_W-1:0] src;
    logic [1:0]            use_src;
    logic [1:0]            stall_op;
    logic [1:0][FWD_W-1:0] fwd_op;

    logic advance;
    logic insert;

    assign src[0]     = rs;
    assign src[1]     = rt;
    assign use_src[0] = use_rs;
    assign use_src[1] = use_rt;

    // Index 0 resolves the rs operand, index 1 the rt operand.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_operand
            logic             hit;
            logic             load;
            logic [FWD_W-1:0] idx;
            logic             stall_s;
            logic [FWD_W-1:0] fwd_s;

            sb_match #(
                .PIPE_DEPTH(PIPE_DEPTH),
                .IDX_W     (FWD_W)
            ) u_match (
                .ents_i   (ents_q),
                .src_i    (SB_REG_W'(src[gi])),
                .use_src_i(use_src[gi]),
                .hit_o    (hit),
                .idx_o    (idx),
                .load_o   (load)
            );

            always_comb begin
                stall_s = 1'b0;
                fwd_s   = FWD_RF_W;
                if (hit) begin
                    if (FORWARD == 0) begin
                        stall_s = 1'b1;
                    end else if (load && (idx < LOAD_READY_W)) begin
                        stall_s = 1'b1;
                    end else begin
                        fwd_s = idx + FWD_W'(1);
                    end
                end
            end

            assign stall_op[gi] = stall_s;
            assign fwd_op[gi]   = fwd_s;
        end
    endgenerate

    // A squashed or empty decode slot never holds the front end.
    assign stall = (|stall_op) & issue_valid & ~flush;
    assign fwd_a = fwd_op[0];
    assign fwd_b = fwd_op[1];

    assign advance = ihit & ~mem_freeze;
    assign insert  = issue_valid & dst_wen & (dst != '0) & ~stall & ~flush;

    always_comb begin
        ents_d = ents_q;
        if (advance) begin
            for (int i = PIPE_DEPTH - 1; i >= 1; i--) begin
                ents_d[i] = ents_q[i-1];
            end
            if (insert) begin
                ents_d[0].valid = 1'b1;
                ents_d[0].dst   = SB_REG_W'(dst);
                ents_d[0].load  = dst_load;
            end else begin
                ents_d[0] = '0;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ents_q <= '0;
        end else begin
            ents_q <= ents_d;
        end
    end

    always_comb begin
        inflight = '0;
        for (int i = 0; i < PIPE_DEPTH; i++) begin
            inflight = inflight + FWD_W'(ents_q[i].valid);
        end
    end

endmodule

// File: tb/tb_decode_scoreboard.sv
// Directed bench for decode_scoreboard: a forwarding instance and a
// no-forwarding instance share one stimulus stream.
module tb_decode_scoreboard;

    logic       CLK = 1'b0;
    logic       nRST;
    logic       ihit, mem_freeze, flush, issue_valid;
    logic [4:0] rs, rt, dst;
    logic       use_rs, use_rt, dst_wen, dst_load;

    logic       stall0, stall1;
    logic [1:0] fwd_a0, fwd_b0, infl0;
    logic [1:0] fwd_a1, fwd_b1, infl1;

    int n_vec = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    decode_scoreboard u0 (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .mem_freeze(mem_freeze), .flush(flush),
        .issue_valid(issue_valid), .rs(rs), .rt(rt), .use_rs(use_rs), .use_rt(use_rt),
        .dst(dst), .dst_wen(dst_wen), .dst_load(dst_load),
        .stall(stall0), .fwd_a(fwd_a0), .fwd_b(fwd_b0), .inflight(infl0)
    );

    decode_scoreboard #(.FORWARD(0)) u1 (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .mem_freeze(mem_freeze), .flush(flush),
        .issue_valid(issue_valid), .rs(rs), .rt(rt), .use_rs(use_rs), .use_rt(use_rt),
        .dst(dst), .dst_wen(dst_wen), .dst_load(dst_load),
        .stall(stall1), .fwd_a(fwd_a1), .fwd_b(fwd_b1), .inflight(infl1)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic ins(input logic iv, input logic [4:0] a, input logic ua,
                       input logic [4:0] b, input logic ub,
                       input logic [4:0] d, input logic we, input logic ld);
        issue_valid = iv; rs = a; use_rs = ua; rt = b; use_rt = ub;
        dst = d; dst_wen = we; dst_load = ld;
        #3;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) begin
            ins(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
            tick();
        end
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        tick();
        nRST = 1'b1;
    endtask

    initial begin
        nRST = 1'b0; ihit = 1'b1; mem_freeze = 1'b0; flush = 1'b0;
        ins(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        do_reset();

        // Reset state
        ins(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        chk("rst_stall", stall0, 0);
        chk("rst_fwd_a", fwd_a0, 0);
        chk("rst_inflight", infl0, 0);
        $display("txn reset: stall=%0d fwd_a=%0d inflight=%0d", stall0, fwd_a0, infl0);

        // add $3 then a reader of $3
        ins(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
        chk("add3_stall", stall0, 0);
        tick();
        chk("add3_inflight", infl0, 1);
        ins(1'b1, 5'd3, 1'b1, 5'd2, 1'b1, 5'd6, 1'b1, 1'b0);
        chk("raw_fwd_a", fwd_a0, 1);
        chk("raw_fwd_b", fwd_b0, 0);
        chk("raw_stall", stall0, 0);
        $display("txn add-use: fwd_a=%0d stall=%0d", fwd_a0, stall0);
        tick();
        ins(1'b1, 5'd8, 1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0);
        chk("unrel_fwd_a", fwd_a0, 0);
        chk("unrel_fwd_b", fwd_b0, 0);
        chk("unrel_inflight", infl0, 2);
        tick();
        drain();
        chk("drain_inflight", infl0, 0);

        // load $5 then a reader via rt
        ins(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
        tick();
        ins(1'b1, 5'd1, 1'b1, 5'd5, 1'b1, 5'd10, 1'b1, 1'b0);
        for (int c = 0; c < 2; c++) begin
            chk("lu_stall", stall0, 1);
            chk("lu_inflight", infl0, 1);
            $display("txn load-use cycle %0d: stall=%0d inflight=%0d", c, stall0, infl0);
            tick();
            #3;
        end
        chk("lu_release_stall", stall0, 0);
        chk("lu_release_fwd_b", fwd_b0, 3);
        chk("lu_release_inflight", infl0, 1);
        tick();
        chk("lu_after_inflight", infl0, 1);
        drain();

        // write to $0 is dropped, jal writes $31
        ins(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
        tick();
        chk("r0_inflight", infl0, 0);
        ins(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd31, 1'b1, 1'b0);
        tick();
        ins(1'b1, 5'd0, 1'b1, 5'd31, 1'b1, 5'd0, 1'b0, 1'b0);
        chk("r0_fwd_a", fwd_a0, 0);
        chk("r31_fwd_b", fwd_b0, 1);
        chk("r0_r31_stall", stall0, 0);
        $display("txn r0/r31: fwd_a=%0d fwd_b=%0d stall=%0d", fwd_a0, fwd_b0, stall0);
        tick();
        drain();

        // two writers of $7 at entries 0 and 2
        ins(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
        tick();
        ins(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0);
        tick();
        ins(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
        tick();
        ins(1'b1, 5'd7, 1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 1'b0);
        chk("youngest_fwd_a", fwd_a0, 1);
        chk("mid_fwd_b", fwd_b0, 2);
        chk("three_inflight", infl0, 3);
        $display("txn youngest: fwd_a=%0d fwd_b=%0d", fwd_a0, fwd_b0);
        tick();
        drain();

        // flush beats a load-use stall; a bubble enters entry 0
        ins(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
        tick();
        flush = 1'b1;
        ins(1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 5'd12, 1'b1, 1'b0);
        chk("flush_stall", stall0, 0);
        chk("flush_fwd_b", fwd_b0, 0);
        tick();
        flush = 1'b0;
        ins(1'b0, 5'd12, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        chk("flush_bubble_fwd_a", fwd_a0, 0);
        chk("flush_bubble_inflight", infl0, 1);
        $display("txn flush: fwd_a=%0d inflight=%0d", fwd_a0, infl0);

        // mem_freeze holds everything while the load sits at entry 1
        mem_freeze = 1'b1;
        ins(1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 5'd13, 1'b1, 1'b0);
        for (int c = 0; c < 4; c++) begin
            chk("freeze_stall", stall0, 1);
            chk("freeze_fwd_b", fwd_b0, 0);
            chk("freeze_inflight", infl0, 1);
            $display("txn freeze cycle %0d: stall=%0d fwd_b=%0d inflight=%0d", c, stall0, fwd_b0, infl0);
            tick();
            #3;
        end
        mem_freeze = 1'b0;

        // asynchronous reset while stalled
        chk("prereset_stall", stall0, 1);
        #1;
        nRST = 1'b0;
        #1;
        chk("async_rst_stall", stall0, 0);
        chk("async_rst_inflight", infl0, 0);
        chk("async_rst_fwd_b", fwd_b0, 0);
        $display("txn async reset: stall=%0d inflight=%0d", stall0, infl0);
        tick();
        nRST = 1'b1;
        drain();

        // no-forwarding instance: add $4 then reader stalls until retirement
        ins(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0);
        tick();
        ins(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd14, 1'b1, 1'b0);
        chk("fwd_mode_fwd_a", fwd_a0, 1);
        for (int c = 0; c < 3; c++) begin
            chk("nofwd_stall", stall1, 1);
            chk("nofwd_fwd_a", fwd_a1, 0);
            chk("nofwd_inflight", infl1, 1);
            $display("txn nofwd cycle %0d: stall=%0d fwd_a=%0d", c, stall1, fwd_a1);
            tick();
            #3;
        end
        chk("nofwd_release_stall", stall1, 0);
        chk("nofwd_release_fwd_a", fwd_a1, 0);
        chk("nofwd_release_inflight", infl1, 0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
